// File: rtl/mult_seq_32bit.sv
// Iterative 32x32 unsigned shift-add multiplier (one add-and-shift per clock) built around one adder_32bit.
// Latency: 33 cycles from the accepting edge to the done pulse; 1 cycle for zero operands with MULT_ZERO_SKIP_EN.
// Backpressure: none; start is sampled only in IDLE, and a start seen in RUN or DONE is dropped, not queued.
// Optional feature macro: MULT_ZERO_SKIP_EN (a zero operand skips straight to DONE with a zero product).

// Plain ripple-style 32-bit adder with carry out and signed overflow flag.
module adder_32bit (
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  // Carry out falls out of a 33-bit add; overflow compares operand and result signs.
  always_comb begin
    {cout, sum} = {1'b0, in_a} + {1'b0, in_b} + {32'b0, cin};
    overflow    = (in_a[31] == in_b[31]) && (sum[31] != in_a[31]);
  end

endmodule

module mult_seq_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf_unused;
  logic             zero_op;

`ifdef MULT_ZERO_SKIP_EN
  // A zero operand makes the product trivially zero, so the iterations can be skipped.
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Low bit of the multiplier half selects whether the multiplicand is added this iteration.
  assign add_b = prod_lo_q[0] ? mcand_q : '0;

  adder_32bit u_adder (
    .in_a     (prod_hi_q),
    .in_b     (add_b),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf_unused)
  );

  // State and datapath registers; rst aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      count_q   <= count_d;
    end
  end

  // Next-state: accept in IDLE, iterate WIDTH times in RUN, spend one cycle in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = zero_op ? S_DONE : S_RUN;
      S_RUN:  if (count_q == LAST_ITER) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, then add-and-shift the 65-bit {cout, hi, lo} right by one.
  always_comb begin
    mcand_d   = mcand_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = in_a;
          prod_hi_d = '0;
          prod_lo_d = zero_op ? '0 : in_b;
          count_d   = '0;
        end
      end
      S_RUN: begin
        {prod_hi_d, prod_lo_d} = {add_cout, add_sum, prod_lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are pure decodes of the state and the product registers.
  always_comb begin
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    product_hi = prod_hi_q;
    product_lo = prod_lo_q;
  end

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Self-checking bench for mult_seq_32bit against a plain a*b reference.
module tb_mult_seq_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        busy, done;
  logic [31:0] product_hi, product_lo;

  int errors = 0;
  int checks = 0;

  mult_seq_32bit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_a       (in_a),
    .in_b       (in_b),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width unsigned product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Expected cycles from accepting edge to done sample.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 33;
  endfunction

  // Count negedge samples until done (bounded); lat=0 means timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, bc;
    logic [63:0] exp_p;
    exp_p = ref_mul(a, b);
    @(negedge clk);
    start = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; in_a = $urandom; in_b = $urandom;
    wait_done(lat, bc);
    chk({tag, " latency"}, 64'(lat), 64'(ref_lat(a, b)));
    chk({tag, " busy cycles"}, 64'(bc), 64'(ref_lat(a, b) - 1));
    chk({tag, " product"}, {product_hi, product_lo}, exp_p);
    @(negedge clk);
    chk({tag, " done single pulse"}, 64'(done), 64'd0);
    chk({tag, " product hold"}, {product_hi, product_lo}, exp_p);
  endtask

  initial begin
    int lat, bc, ndone;
    logic [31:0] ra, rb;

    // Reset state
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic and max-value products
    do_op(32'd3, 32'd5, "3x5");
    chk("3x5 lo literal", 64'(product_lo), 64'h0000000F);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, "max");
    chk("max literal", {product_hi, product_lo}, 64'hFFFFFFFE_00000001);

    // Start and operand changes during RUN are ignored
    @(negedge clk);
    start = 1'b1; in_a = 32'h00010000; in_b = 32'h00010000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; in_a = 32'h0000_00FF; in_b = 32'h0000_0003;
    @(negedge clk);
    in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("ignore latency", 64'(lat), 64'd21);
    chk("ignore busy", 64'(bc), 64'd20);
    chk("ignore product", {product_hi, product_lo}, 64'h00000001_00000000);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignore extra done", 64'(ndone), 64'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; in_a = 32'h12345678; in_b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort product", {product_hi, product_lo}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    do_op(32'd7, 32'd9, "7x9");
    chk("7x9 lo literal", 64'(product_lo), 64'h3F);

    // Zero operand
    do_op(32'd0, 32'h12345678, "zero a");
    do_op(32'h9ABCDEF0, 32'd0, "zero b");

    // Back-to-back with start held high through DONE
    @(negedge clk);
    start = 1'b1; in_a = 32'd2; in_b = 32'd2;
    @(posedge clk);
    #1;
    in_a = 32'h80000000; in_b = 32'd2;
    wait_done(lat, bc);
    chk("b2b first latency", 64'(lat), 64'd33);
    chk("b2b first product", {product_hi, product_lo}, 64'd4);
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle gap done", 64'(done), 64'd0);
    chk("b2b idle gap busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("b2b second latency", 64'(lat), 64'd33);
    chk("b2b second product", {product_hi, product_lo}, 64'h00000001_00000000);

    // Randomized operands against the reference
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 6) ra = 32'h8000_0001;
      do_op(ra, rb, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
